hs_flow_quantizer: RTL and testbench

- Downstream stage of hsOptFlowTop: consumes its per-pixel 26-bit fixed-point flow stream (u, v) plus frame sync.
- Produces 8-bit saturated signed flow components and an 8-bit L1 flow magnitude for display and packing.
- Also produces per-frame statistics: max magnitude and saturated-pixel count.
- Continuous one-pixel-per-cycle stream, no back-pressure, fixed 2-cycle latency.

---
 rtl/hs_flow_quantizer.sv | 177 +++++++++++++++++
 tb/tb_hs_flow_quantizer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_flow_quantizer.sv
// hs_flow_quantizer: turns the 26-bit fixed-point (u, v) flow stream into
// 8-bit saturated components plus an L1 magnitude, two register stages deep,
// and gathers per-frame statistics (max magnitude, saturated-pixel count).
module hs_flow_quantizer #(
   parameter int FP_WIDTH     = 26,
   parameter int FRAC_BITS    = 12,
   parameter int OUT_FRAC     = 2,
   parameter int IMAGE_WIDTH  = 512,
   parameter int IMAGE_HEIGHT = 256,
   parameter int CNT_W        = 18
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                io_frame_sync_in,
   input  logic [FP_WIDTH-1:0] io_data_in_u,
   input  logic [FP_WIDTH-1:0] io_data_in_v,
   output logic                io_frame_sync_out,
   output logic [7:0]          io_data_out_u,
   output logic [7:0]          io_data_out_v,
   output logic [7:0]          io_data_out_mag,
   output logic                io_data_out_sat,
   output logic                io_stats_valid,
   output logic [7:0]          io_stats_max_mag,
   output logic [CNT_W-1:0]    io_stats_sat_count,
   output logic                io_stats_short
);

   localparam int SHIFT = FRAC_BITS - OUT_FRAC;
   localparam int EXT_W = FP_WIDTH + 1;

   localparam logic signed [EXT_W-1:0] ROUND_C    = EXT_W'(2 ** (SHIFT - 1));
   localparam logic signed [EXT_W-1:0] Q_MAX      = EXT_W'(127);
   localparam logic signed [EXT_W-1:0] Q_MIN      = EXT_W'(-128);
   localparam logic [CNT_W-1:0]        IMAGE_SIZE = CNT_W'(IMAGE_WIDTH * IMAGE_HEIGHT);

   typedef enum logic {
      ST_IDLE,
      ST_COUNT
   } state_t;

   // Round half toward +inf, then clamp to 8 bits; result is {sat, q}.
   // One extra bit of headroom keeps the rounding add from overflowing.
   function automatic logic [8:0] quantize(input logic [FP_WIDTH-1:0] x);
      logic signed [EXT_W-1:0] w_ext;
      w_ext = $signed({x[FP_WIDTH-1], x}) + ROUND_C;
      w_ext = w_ext >>> SHIFT;
      if (w_ext > Q_MAX) begin
         return {1'b1, 8'h7F};
      end else if (w_ext < Q_MIN) begin
         return {1'b1, 8'h80};
      end else begin
         return {1'b0, w_ext[7:0]};
      end
   endfunction

   logic [8:0]       w_q_u;
   logic [8:0]       w_q_v;
   logic             r_s1_sync;
   logic [7:0]       r_s1_u;
   logic [7:0]       r_s1_v;
   logic             r_s1_sat_u;
   logic             r_s1_sat_v;

   logic [8:0]       w_u9;
   logic [8:0]       w_v9;
   logic [8:0]       w_abs_u;
   logic [8:0]       w_abs_v;
   logic [8:0]       w_mag_sum;
   logic [7:0]       w_mag;
   logic             w_sat;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_max;
   logic [CNT_W-1:0] r_satcnt;

   assign w_q_u = quantize(io_data_in_u);
   assign w_q_v = quantize(io_data_in_v);

   // Stage 1: register rounded/clamped components and delayed sync.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_sync  <= 1'b0;
         r_s1_u     <= '0;
         r_s1_v     <= '0;
         r_s1_sat_u <= 1'b0;
         r_s1_sat_v <= 1'b0;
      end else begin
         r_s1_sync               <= io_frame_sync_in;
         {r_s1_sat_u, r_s1_u}    <= w_q_u;
         {r_s1_sat_v, r_s1_v}    <= w_q_v;
      end
   end

   // |q| in 9 bits so -128 maps to +128; the sum only reaches 256 at (-128,-128).
   assign w_u9      = {r_s1_u[7], r_s1_u};
   assign w_v9      = {r_s1_v[7], r_s1_v};
   assign w_abs_u   = w_u9[8] ? 9'(-w_u9) : w_u9;
   assign w_abs_v   = w_v9[8] ? 9'(-w_v9) : w_v9;
   assign w_mag_sum = w_abs_u + w_abs_v;
   assign w_mag     = w_mag_sum[8] ? 8'hFF : w_mag_sum[7:0];
   assign w_sat     = r_s1_sat_u | r_s1_sat_v;

   // Stage 2: register the per-pixel outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         io_frame_sync_out <= 1'b0;
         io_data_out_u     <= '0;
         io_data_out_v     <= '0;
         io_data_out_mag   <= '0;
         io_data_out_sat   <= 1'b0;
      end else begin
         io_frame_sync_out <= r_s1_sync;
         io_data_out_u     <= r_s1_u;
         io_data_out_v     <= r_s1_v;
         io_data_out_mag   <= w_mag;
         io_data_out_sat   <= w_sat;
      end
   end

   // Frame statistics FSM, fed by the pixel being loaded into stage 2 so a
   // short-frame pulse lines up with the new frame's sync on the outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state            <= ST_IDLE;
         r_cnt              <= '0;
         r_max              <= '0;
         r_satcnt           <= '0;
         io_stats_valid     <= 1'b0;
         io_stats_max_mag   <= '0;
         io_stats_sat_count <= '0;
         io_stats_short     <= 1'b0;
      end else begin
         io_stats_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_s1_sync) begin
                  r_state  <= ST_COUNT;
                  r_cnt    <= CNT_W'(1);
                  r_max    <= w_mag;
                  r_satcnt <= CNT_W'(w_sat);
               end
            end
            ST_COUNT: begin
               if (r_cnt == IMAGE_SIZE) begin
                  // Full frame: report; a sync on this very pixel opens the next frame.
                  io_stats_valid     <= 1'b1;
                  io_stats_max_mag   <= r_max;
                  io_stats_sat_count <= r_satcnt;
                  io_stats_short     <= 1'b0;
                  if (r_s1_sync) begin
                     r_cnt    <= CNT_W'(1);
                     r_max    <= w_mag;
                     r_satcnt <= CNT_W'(w_sat);
                  end else begin
                     r_state  <= ST_IDLE;
                  end
               end else if (r_s1_sync) begin
                  io_stats_valid     <= 1'b1;
                  io_stats_max_mag   <= r_max;
                  io_stats_sat_count <= r_satcnt;
                  io_stats_short     <= 1'b1;
                  r_cnt              <= CNT_W'(1);
                  r_max              <= w_mag;
                  r_satcnt           <= CNT_W'(w_sat);
               end else begin
                  r_cnt    <= r_cnt + CNT_W'(1);
                  r_max    <= (w_mag > r_max) ? w_mag : r_max;
                  r_satcnt <= r_satcnt + CNT_W'(w_sat);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hs_flow_quantizer.sv
// Scoreboard bench for hs_flow_quantizer: a driver pushes expected pixels and
// frame statistics from an arithmetic reference model; a monitor compares.
module tb_hs_flow_quantizer;

   localparam int FP_WIDTH  = 26;
   localparam int FRAC_BITS = 12;
   localparam int OUT_FRAC  = 2;
   localparam int IW        = 16;
   localparam int IH        = 8;
   localparam int CNT_W     = 18;
   localparam int SIZE      = IW * IH;
   localparam int SHIFT     = FRAC_BITS - OUT_FRAC;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                sync_in = 1'b0;
   logic [FP_WIDTH-1:0] u_in = '0;
   logic [FP_WIDTH-1:0] v_in = '0;
   logic                sync_out;
   logic [7:0]          out_u;
   logic [7:0]          out_v;
   logic [7:0]          out_mag;
   logic                out_sat;
   logic                st_valid;
   logic [7:0]          st_max;
   logic [CNT_W-1:0]    st_satc;
   logic                st_short;

   always #5 clk = ~clk;

   hs_flow_quantizer #(
      .FP_WIDTH(FP_WIDTH), .FRAC_BITS(FRAC_BITS), .OUT_FRAC(OUT_FRAC),
      .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .io_frame_sync_in(sync_in),
      .io_data_in_u(u_in), .io_data_in_v(v_in),
      .io_frame_sync_out(sync_out), .io_data_out_u(out_u), .io_data_out_v(out_v),
      .io_data_out_mag(out_mag), .io_data_out_sat(out_sat),
      .io_stats_valid(st_valid), .io_stats_max_mag(st_max),
      .io_stats_sat_count(st_satc), .io_stats_short(st_short)
   );

   typedef struct { longint due; bit sync; int u; int v; int mag; bit sat; } pix_t;
   typedef struct { longint due; int maxm; int satc; bit shrt; } st_t;

   pix_t   pq[$];
   st_t    sq[$];
   int     frame_mag[$];
   bit     frame_sat[$];
   bit     counting = 1'b0;
   int     held_max = 0;
   int     held_satc = 0;
   bit     held_short = 1'b0;
   longint edge_cnt = 0;
   int     n_checks = 0;
   int     n_pass = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic void check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
   endfunction

   // Reference quantizer: floor((x + half) / 2^SHIFT), then clamp to 8 bits.
   function automatic void quant(input longint x, output int q, output bit s);
      longint div, n, r;
      div = longint'(1) << SHIFT;
      n = x + div / 2;
      if (n >= 0) r = n / div;
      else        r = -((-n + div - 1) / div);
      if (r > 127)       begin q = 127;    s = 1'b1; end
      else if (r < -128) begin q = -128;   s = 1'b1; end
      else               begin q = int'(r); s = 1'b0; end
   endfunction

   function automatic void report(input longint d, input bit shrt);
      st_t e;
      e.due = d; e.shrt = shrt; e.maxm = 0; e.satc = 0;
      foreach (frame_mag[i]) if (frame_mag[i] > e.maxm) e.maxm = frame_mag[i];
      foreach (frame_sat[i]) e.satc += int'(frame_sat[i]);
      sq.push_back(e);
   endfunction

   // Frame bookkeeping at the level of "pixels belonging to the open frame".
   function automatic void model_stats(input bit s, input int mag, input bit sat, input longint d);
      if (counting && frame_mag.size() == SIZE) begin
         report(d, 1'b0);
         frame_mag.delete(); frame_sat.delete();
         counting = s;
         if (s) begin frame_mag.push_back(mag); frame_sat.push_back(sat); end
      end else if (s) begin
         if (counting) report(d, 1'b1);
         frame_mag.delete(); frame_sat.delete();
         frame_mag.push_back(mag); frame_sat.push_back(sat);
         counting = 1'b1;
      end else if (counting) begin
         frame_mag.push_back(mag); frame_sat.push_back(sat);
      end
   endfunction

   task automatic apply_pix(input bit s, input longint u, input longint v);
      pix_t e;
      int   qu, qv, m;
      bit   su, sv;
      sync_in = s;
      u_in = u[FP_WIDTH-1:0];
      v_in = v[FP_WIDTH-1:0];
      quant(u, qu, su);
      quant(v, qv, sv);
      m = (qu < 0 ? -qu : qu) + (qv < 0 ? -qv : qv);
      if (m > 255) m = 255;
      e.due = edge_cnt + 2; e.sync = s; e.u = qu; e.v = qv; e.mag = m; e.sat = su | sv;
      pq.push_back(e);
      model_stats(s, m, e.sat, e.due);
   endtask

   task automatic drive_pix(input bit s, input longint u, input longint v);
      @(posedge clk); #1;
      apply_pix(s, u, v);
   endtask

   function automatic longint rand_fp();
      int k;
      case ($urandom_range(0, 3))
         0: return longint'($urandom_range(0, 67108863)) - 33554432;
         1: return longint'(int'($urandom_range(0, 1200000)) - 600000);
         2: begin
            k = int'($urandom_range(0, 300)) - 150;
            return longint'(k) * 1024 + 511 + longint'($urandom_range(0, 2));
         end
         default: begin
            k = int'($urandom_range(0, 8)) - 4;
            if ($urandom_range(0, 1) == 0) return 130560 + longint'(k);
            else                           return -131584 + longint'(k);
         end
      endcase
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_pix"}, {sync_out, out_u, out_v, out_mag, out_sat}, 0);
      check({tag, "_stats"}, {st_valid, st_max, st_satc, st_short}, 0);
   endtask

   // Asynchronous reset dropped between clock edges; in-flight work is discarded.
   task automatic mid_reset();
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      pq.delete(); sq.delete();
      frame_mag.delete(); frame_sat.delete();
      counting = 1'b0;
      held_max = 0; held_satc = 0; held_short = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      apply_pix(1'b0, 0, 0);
   endtask

   // Monitor: every cycle carries a pixel; stats either pulse as predicted or hold.
   always @(negedge clk) begin
      pix_t e;
      st_t  s;
      if (pq.size() > 0 && pq[0].due < edge_cnt) begin
         check("pix_missed", pq[0].due, edge_cnt);
         void'(pq.pop_front());
      end
      if (pq.size() > 0 && pq[0].due == edge_cnt) begin
         e = pq.pop_front();
         check("sync_out", longint'(sync_out), longint'(e.sync));
         check("out_u", longint'($signed(out_u)), longint'(e.u));
         check("out_v", longint'($signed(out_v)), longint'(e.v));
         check("out_mag", longint'(out_mag), longint'(e.mag));
         check("out_sat", longint'(out_sat), longint'(e.sat));
      end
      if (sq.size() > 0 && sq[0].due == edge_cnt) begin
         s = sq.pop_front();
         check("stats_valid", longint'(st_valid), 1);
         check("stats_max", longint'(st_max), longint'(s.maxm));
         check("stats_satc", longint'(st_satc), longint'(s.satc));
         check("stats_short", longint'(st_short), longint'(s.shrt));
         held_max = s.maxm; held_satc = s.satc; held_short = s.shrt;
      end else begin
         check("stats_idle", longint'(st_valid), 0);
         check("stats_hold", {st_max, st_satc, st_short},
               {8'(held_max), CNT_W'(held_satc), held_short});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset_state");
      @(posedge clk); #1;
      reset = 1'b1;
      apply_pix(1'b0, rand_fp(), rand_fp());

      // Pre-sync traffic: quantized but never counted
      for (int i = 0; i < 499; i++) drive_pix(1'b0, rand_fp(), rand_fp());

      // Short frame: rounding pixel with sync, saturation pixel, random rest
      drive_pix(1'b1, 6144, -1536);
      drive_pix(1'b0, 163840, -163840);
      for (int i = 0; i < 98; i++) drive_pix(1'b0, rand_fp(), rand_fp());

      // Full frame of u=1.0 with one saturating pixel
      for (int i = 0; i < SIZE; i++)
         drive_pix(i == 0, (i == 50) ? 163840 : 4096, 0);

      // Next frame opens on the pixel right after the last one
      for (int i = 0; i < SIZE; i++) drive_pix(i == 0, rand_fp(), rand_fp());
      for (int i = 0; i < 5; i++) drive_pix(1'b0, rand_fp(), rand_fp());

      // Frame cut by asynchronous reset, then a clean full frame
      for (int i = 0; i < 60; i++) drive_pix(i == 0, rand_fp(), rand_fp());
      mid_reset();
      for (int i = 0; i < 3; i++) drive_pix(1'b0, rand_fp(), rand_fp());
      for (int i = 0; i < SIZE; i++) drive_pix(i == 0, rand_fp(), rand_fp());
      for (int i = 0; i < 3; i++) drive_pix(1'b0, rand_fp(), rand_fp());

      // Random sync placement
      for (int i = 0; i < 400; i++)
         drive_pix((i == 0) || ($urandom_range(0, 39) == 0), rand_fp(), rand_fp());

      // Drain
      for (int i = 0; i < 4; i++) drive_pix(1'b0, 0, 0);
      for (int i = 0; i < 20 && (pq.size() > 0 || sq.size() > 0); i++) @(negedge clk);
      @(negedge clk);
      check("drain_pix_queue", pq.size(), 0);
      check("drain_stats_queue", sq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
